// File: rtl/aib_gearbox_pkg.sv
// Shared types and framing constants for the AIB transmit gearbox.
// Control bits sit at OUT_W minus the offsets below.
package aib_gearbox_pkg;

  typedef enum logic {IDLE, SEND} state_t;

  localparam int VALID_BIT = 1;
  localparam int SOF_BIT   = 2;
  localparam int PAR_BIT   = 3;

  function automatic int calc_beats(input int bus_w, input int pay_w);
    return (bus_w + pay_w - 1) / pay_w;
  endfunction

  // The lowest control bit bounds the payload field from above.
  function automatic int pay_width(input int out_w, input bit parity_en);
    return out_w - (parity_en ? PAR_BIT : SOF_BIT);
  endfunction

endpackage

// File: rtl/aib_tx_gearbox_if.sv
// Core-side word handshake, credit return and AIB beat outputs of the TX gearbox.
// The master modport is the driver side; the slave modport is the gearbox.
interface aib_tx_gearbox_if #(
  parameter int BUS_W   = 72,
  parameter int NUM_CH  = 1,
  parameter int LANE_W  = 20,
  parameter int CREDITS = 8
);
  logic                             i_bus_tx_valid;
  logic                             o_bus_tx_ready;
  logic [BUS_W-1:0]                 i_bus_tx_data;
  logic                             i_credit_return;
  logic [NUM_CH*LANE_W-1:0]         o_aib_tx_data0;
  logic [NUM_CH*LANE_W-1:0]         o_aib_tx_data1;
  logic [$clog2(CREDITS+1)-1:0]     o_credits;
  logic                             o_credit_err;

  modport master (
    output i_bus_tx_valid, i_bus_tx_data, i_credit_return,
    input  o_bus_tx_ready, o_aib_tx_data0, o_aib_tx_data1, o_credits, o_credit_err
  );

  modport slave (
    input  i_bus_tx_valid, i_bus_tx_data, i_credit_return,
    output o_bus_tx_ready, o_aib_tx_data0, o_aib_tx_data1, o_credits, o_credit_err
  );
endinterface

// File: rtl/aib_credit_counter.sv
// Far-side receive credit tracker: decrements on accept, increments on return,
// saturates at CREDITS and flags a sticky error on a return at full count.
module aib_credit_counter #(
  parameter int CREDITS = 8,
  parameter int CW      = $clog2(CREDITS+1)
) (
  input  logic          i_aib_tx_clk,
  input  logic          i_rst_n,
  input  logic          i_dec,
  input  logic          i_inc,
  output logic [CW-1:0] o_credits,
  output logic          o_err
);

  always_ff @(posedge i_aib_tx_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_credits <= CW'(CREDITS);
      o_err     <= 1'b0;
    end else if (i_inc && !i_dec) begin
      if (o_credits == CW'(CREDITS)) o_err <= 1'b1;
      else                           o_credits <= o_credits + 1'b1;
    end else if (i_dec && !i_inc) begin
      o_credits <= o_credits - 1'b1;
    end
  end

endmodule

// File: rtl/aib_tx_gearbox.sv
// AIB transmit gearbox: frames BUS_W-bit words into BEATS valid/SOF-tagged beats.
// Define AIB_TX_GEARBOX_PARITY_EN to add an even-parity bit over each beat's payload.
//
// state | meaning
// IDLE  | nothing on the output; ready whenever credits remain
// SEND  | beat_q is the index of the beat currently on the output register
module aib_tx_gearbox
  import aib_gearbox_pkg::*;
#(
  parameter int BUS_W   = 72,
  parameter int NUM_CH  = 1,
  parameter int LANE_W  = 20,
  parameter int CREDITS = 8
) (
  input logic             i_aib_tx_clk,
  input logic             i_rst_n,
  aib_tx_gearbox_if.slave bus
);

`ifdef AIB_TX_GEARBOX_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif
  localparam int HALF_W = NUM_CH * LANE_W;
  localparam int OUT_W  = 2 * HALF_W;
  localparam int PAY_W  = pay_width(OUT_W, PARITY_EN);
  localparam int BEATS  = calc_beats(BUS_W, PAY_W);
  localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PAD_W  = BEATS * PAY_W;
  localparam int CW     = $clog2(CREDITS + 1);
  localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

  state_t           state_q, state_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic [PAD_W-1:0] word_q, word_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic [PAY_W-1:0] payload;
  logic [CW-1:0]    credits;
  logic             credit_err;
  logic             ready;
  logic             accept;
  logic             emit;

  // Ready is held low during reset so nothing is accepted while the counter restores.
  assign ready  = i_rst_n && (credits != '0) && (state_q == IDLE || beat_q == LAST);
  assign accept = bus.i_bus_tx_valid && ready;

  aib_credit_counter #(.CREDITS(CREDITS)) u_credits (
    .i_aib_tx_clk (i_aib_tx_clk),
    .i_rst_n      (i_rst_n),
    .i_dec        (accept),
    .i_inc        (bus.i_credit_return),
    .o_credits    (credits),
    .o_err        (credit_err)
  );

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    word_d  = word_q;
    emit    = 1'b0;
    if (accept) begin
      state_d = SEND;
      beat_d  = '0;
      word_d  = PAD_W'(bus.i_bus_tx_data);
      emit    = 1'b1;
    end else if (state_q == SEND) begin
      if (beat_q == LAST) begin
        state_d = IDLE;
        beat_d  = '0;
      end else begin
        beat_d = beat_q + 1'b1;
        emit   = 1'b1;
      end
    end
  end

  always_comb begin
    payload = word_d[int'(beat_d) * PAY_W +: PAY_W];
    out_d   = '0;
    if (emit) begin
      out_d[OUT_W-VALID_BIT] = 1'b1;
      out_d[OUT_W-SOF_BIT]   = (beat_d == '0);
`ifdef AIB_TX_GEARBOX_PARITY_EN
      out_d[OUT_W-PAR_BIT]   = ^payload;
`endif
      out_d[PAY_W-1:0]       = payload;
    end
  end

  always_ff @(posedge i_aib_tx_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      word_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      word_q  <= word_d;
      out_q   <= out_d;
    end
  end

  assign bus.o_bus_tx_ready = ready;
  assign bus.o_aib_tx_data0 = out_q[HALF_W-1:0];
  assign bus.o_aib_tx_data1 = out_q[OUT_W-1:HALF_W];
  assign bus.o_credits      = credits;
  assign bus.o_credit_err   = credit_err;

endmodule

// File: tb/tb_aib_tx_gearbox.sv
// Bench for aib_tx_gearbox: queue-based beat model checked every cycle,
// directed frame/credit scenarios with literal expectations, then random traffic.
module tb_aib_tx_gearbox;

  localparam int BUS_W   = 72;
  localparam int NUM_CH  = 1;
  localparam int LANE_W  = 20;
  localparam int CREDITS = 8;
  localparam int HALF_W  = NUM_CH * LANE_W;
  localparam int OUT_W   = 2 * HALF_W;
`ifdef AIB_TX_GEARBOX_PARITY_EN
  localparam int PAY_W   = OUT_W - 3;
`else
  localparam int PAY_W   = OUT_W - 2;
`endif
  localparam int BEATS   = (BUS_W + PAY_W - 1) / PAY_W;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  aib_tx_gearbox_if #(.BUS_W(BUS_W), .NUM_CH(NUM_CH), .LANE_W(LANE_W), .CREDITS(CREDITS)) bus_if ();

  aib_tx_gearbox #(.BUS_W(BUS_W), .NUM_CH(NUM_CH), .LANE_W(LANE_W), .CREDITS(CREDITS)) dut (
    .i_aib_tx_clk (clk),
    .i_rst_n      (rst_n),
    .bus          (bus_if)
  );

  always #5 clk = ~clk;

  // Reference model: pending beats queue, expected output register, credit count.
  logic [OUT_W-1:0] mq[$];
  logic [OUT_W-1:0] m_out     = '0;
  int               m_credits = CREDITS;
  bit               m_err     = 1'b0;

  function automatic bit m_ready();
    return rst_n && (m_credits > 0) && (mq.size() == 0);
  endfunction

  function automatic logic [OUT_W-1:0] make_beat(input logic [BUS_W-1:0] w, input int k);
    logic [BEATS*PAY_W-1:0] pad;
    logic [PAY_W-1:0]       p;
    logic [OUT_W-1:0]       b;
    pad = '0;
    pad[BUS_W-1:0] = w;
    p = PAY_W'(pad >> (k * PAY_W));
    b = '0;
    b[PAY_W-1:0] = p;
    b[OUT_W-1]   = 1'b1;
    b[OUT_W-2]   = (k == 0);
`ifdef AIB_TX_GEARBOX_PARITY_EN
    b[OUT_W-3]   = ^p;
`endif
    return b;
  endfunction

  function automatic logic [BUS_W-1:0] rand_word();
    return BUS_W'({$urandom(), $urandom(), $urandom()});
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_out     = '0;
      m_credits = CREDITS;
      m_err     = 1'b0;
    end else begin
      bit acc;
      bit ret;
      acc = bus_if.i_bus_tx_valid && m_ready();
      ret = bus_if.i_credit_return;
      if (acc && !ret) m_credits--;
      else if (ret && !acc) begin
        if (m_credits == CREDITS) m_err = 1'b1;
        else m_credits++;
      end
      if (acc) for (int k = 0; k < BEATS; k++) mq.push_back(make_beat(bus_if.i_bus_tx_data, k));
      m_out = (mq.size() > 0) ? mq.pop_front() : '0;
    end
  end

  always @(negedge clk) begin
    chk("data0",   bus_if.o_aib_tx_data0, m_out[HALF_W-1:0]);
    chk("data1",   bus_if.o_aib_tx_data1, m_out[OUT_W-1:HALF_W]);
    chk("ready",   bus_if.o_bus_tx_ready, m_ready());
    chk("credits", bus_if.o_credits,      m_credits);
    chk("err",     bus_if.o_credit_err,   m_err);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic ret_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      bus_if.i_credit_return = 1'b1;
      tick();
      bus_if.i_credit_return = 1'b0;
    end
  endtask

  logic [BUS_W-1:0] w;

  initial begin
    bus_if.i_bus_tx_valid  = 1'b0;
    bus_if.i_bus_tx_data   = '0;
    bus_if.i_credit_return = 1'b0;
    #1 rst_n = 1'b0;
    tick();
    tick();
    chk("rst_credits", bus_if.o_credits, CREDITS);
    chk("rst_ready", bus_if.o_bus_tx_ready, 0);
    chk("rst_beat", {bus_if.o_aib_tx_data1, bus_if.o_aib_tx_data0}, 0);
    chk("rst_err", bus_if.o_credit_err, 0);
    rst_n = 1'b1;
    tick();

    // Single all-ones word.
    chk("idle_ready", bus_if.o_bus_tx_ready, 1);
    bus_if.i_bus_tx_valid = 1'b1;
    bus_if.i_bus_tx_data  = '1;
    tick();
    bus_if.i_bus_tx_valid = 1'b0;
    bus_if.i_bus_tx_data  = rand_word();
`ifndef AIB_TX_GEARBOX_PARITY_EN
    chk("ones_beat0", {bus_if.o_aib_tx_data1, bus_if.o_aib_tx_data0}, 40'hFFFFFFFFFF);
`endif
    tick();
`ifndef AIB_TX_GEARBOX_PARITY_EN
    chk("ones_beat1_d1", bus_if.o_aib_tx_data1, 20'h83FFF);
    chk("ones_beat1_d0", bus_if.o_aib_tx_data0, 20'hFFFFF);
`endif
    tick();
    chk("ones_idle", {bus_if.o_aib_tx_data1, bus_if.o_aib_tx_data0}, 0);
    ret_pulses(1);
    chk("ones_credits_back", bus_if.o_credits, CREDITS);

    // Back-to-back: valid held for cycles 0..6 gives four words.
    for (int c = 0; c < 10; c++) begin
      if (c < 8) chk("b2b_ready", bus_if.o_bus_tx_ready, (c % 2 == 0 && c <= 6));
      if (c >= 1 && c <= 8) begin
        chk("b2b_valid", bus_if.o_aib_tx_data1[HALF_W-1], 1);
        chk("b2b_sof", bus_if.o_aib_tx_data1[HALF_W-2], (c % 2 == 1));
      end
      bus_if.i_bus_tx_valid = (c <= 6);
      bus_if.i_bus_tx_data  = rand_word();
      tick();
    end
    bus_if.i_bus_tx_valid = 1'b0;
    chk("b2b_credits", bus_if.o_credits, CREDITS - 4);

    // Exhaustion: eight words with no returns.
    ret_pulses(4);
    chk("exh_start", bus_if.o_credits, CREDITS);
    bus_if.i_bus_tx_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      bus_if.i_bus_tx_data = rand_word();
      tick();
    end
    chk("exh_credits", bus_if.o_credits, 0);
    chk("exh_ready", bus_if.o_bus_tx_ready, 0);
    tick();
    tick();
    chk("exh_ready_held", bus_if.o_bus_tx_ready, 0);
    bus_if.i_bus_tx_valid = 1'b0;
    ret_pulses(1);
    chk("exh_ret_credits", bus_if.o_credits, 1);
    chk("exh_ret_ready", bus_if.o_bus_tx_ready, 1);

    // Accept and return in the same cycle at one credit.
    bus_if.i_bus_tx_valid  = 1'b1;
    bus_if.i_bus_tx_data   = rand_word();
    bus_if.i_credit_return = 1'b1;
    tick();
    bus_if.i_bus_tx_valid  = 1'b0;
    bus_if.i_credit_return = 1'b0;
    chk("simul_credits", bus_if.o_credits, 1);
    tick();
    tick();
    tick();

    // Overflow: return at full count.
    ret_pulses(CREDITS - 1);
    chk("ovf_pre", bus_if.o_credits, CREDITS);
    ret_pulses(1);
    chk("ovf_err", bus_if.o_credit_err, 1);
    chk("ovf_credits", bus_if.o_credits, CREDITS);
    for (int c = 0; c < 5; c++) tick();
    chk("ovf_sticky", bus_if.o_credit_err, 1);

    // Reset during beat 0.
    bus_if.i_bus_tx_valid = 1'b1;
    bus_if.i_bus_tx_data  = rand_word();
    tick();
    bus_if.i_bus_tx_valid = 1'b0;
    chk("mf_sof", bus_if.o_aib_tx_data1[HALF_W-2], 1);
    rst_n = 1'b0;
    #1;
    chk("mf_async_beat", {bus_if.o_aib_tx_data1, bus_if.o_aib_tx_data0}, 0);
    chk("mf_async_ready", bus_if.o_bus_tx_ready, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("mf_credits", bus_if.o_credits, CREDITS);
    chk("mf_err", bus_if.o_credit_err, 0);
    chk("mf_ready", bus_if.o_bus_tx_ready, 1);
    w = rand_word();
    bus_if.i_bus_tx_valid = 1'b1;
    bus_if.i_bus_tx_data  = w;
    tick();
    bus_if.i_bus_tx_valid = 1'b0;
    chk("mf_next_sof", bus_if.o_aib_tx_data1[HALF_W-2], 1);
    chk("mf_next_beat", {bus_if.o_aib_tx_data1, bus_if.o_aib_tx_data0}, make_beat(w, 0));
    for (int c = 0; c < 4; c++) tick();

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      bus_if.i_bus_tx_valid  = ($urandom_range(3) != 0);
      bus_if.i_bus_tx_data   = rand_word();
      bus_if.i_credit_return = ($urandom_range(3) == 0);
      tick();
    end
    bus_if.i_bus_tx_valid  = 1'b0;
    bus_if.i_credit_return = 1'b0;
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
